mcs_bus_bridge_nslot: RTL and testbench
=======================================

# mcs_bus_bridge_nslot

Parametrised successor to the single-window MicroBlaze MCS I/O-bus bridge. It decodes the MCS I/O bus into `N_SLOT` FPro target windows (MMIO, video, or others), each with its own chip-select. It registers each transaction and optionally waits for a per-slot acknowledge with a timeout, so slow targets stall the CPU safely. It sits between the `cpu` MCS instance and the MMIO/video subsystems in the top-level sampler design.

## Interface
Parameters:
- `BRG_BASE`, default `32'hc000_0000`: bridge base byte address. Only the bits above the decoded field are compared.
- `N_SLOT`, default 2: number of FPro target windows. Must be 1..8.
- `ADDR_W`, default 21: FPro word-address width per slot.
- `TIMEOUT`, default 255: maximum wait cycles for an acknowledge. Must be 1..65535.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_addr_strobe`, `io_read_strobe`, `io_write_strobe`  in  1 each  MCS bus strobes.
- `io_byte_enable`  in  4  MCS byte enables.
- `io_address`  in  32  MCS byte address.
- `io_write_data`  in  32  MCS write data.
- `io_read_data`  out  32  read data returned to the MCS.
- `io_ready`  out  1  one-cycle transaction-complete pulse.
- `fp_cs`  out  N_SLOT  one-hot target select.
- `fp_wr`, `fp_rd`  out  1 each  one-cycle access pulses.
- `fp_addr`  out  ADDR_W  word address, taken from `io_address[ADDR_W+1:2]`.
- `fp_be`  out  4  latched byte enables.
- `fp_wr_data`  out  32  latched write data.
- `fp_rd_data`  in  32*N_SLOT  per-slot read data. Slot k occupies `[32k+31:32k]`.
- `fp_ack`  in  N_SLOT  per-slot acknowledge.
- `err_clr`  in  1  clears the sticky error flags.
- `err_flags`  out  3  sticky error flags: {overrun, timeout, miss}.

## Operation
- Decoding:
  - SEL_W = max(1, clog2(N_SLOT)).
  - Slot index is `io_address[ADDR_W+2 +: SEL_W]`.
  - The transaction is a hit when `io_address[31:ADDR_W+2+SEL_W]` equals the same bits of `BRG_BASE` and the slot index is below N_SLOT.
- State machine: IDLE, REQ, WAIT, DONE.
- IDLE: on `io_addr_strobe` together with exactly one of the read/write strobes, latch address, byte enables, write data, operation and slot.
  - Hit: go to REQ.
  - Miss: set `err_flags[0]` and go to DONE with read data 0.
  - Both read and write strobes high: treat as a write.
- REQ: assert `fp_cs[slot]` and pulse `fp_wr` or `fp_rd` for this cycle only.
  - If `fp_ack[slot]` is high, capture the slot's `fp_rd_data` (reads) and go to DONE.
  - Otherwise go to WAIT.
- WAIT: hold `fp_cs[slot]`, with `fp_wr` and `fp_rd` low. Increment the timeout counter each cycle.
  - On ack: capture read data and go to DONE.
  - When the counter reaches TIMEOUT: set `err_flags[1]`, set read data to 0, and go to DONE.
- DONE: pulse `io_ready` for one cycle. `io_read_data` is valid in this cycle and held until the next DONE. Return to IDLE.
- A new strobe in any state other than IDLE is ignored and sets `err_flags[2]`.
- `err_clr` clears all flags. An error event in the same cycle as `err_clr` wins (the flag stays set).
- Write data is never returned. `io_read_data` is updated only by reads and misses.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset mid-transaction: abort immediately with no `io_ready` pulse. `fp_cs` drops asynchronously.

## Timing
- The strobe is sampled at edge 0. REQ (cs plus rd/wr pulse) occupies cycle 1.
- With a zero-wait ack (ack in REQ), `io_ready` is in cycle 2. This is the minimum latency of 2.
- An ack after n WAIT cycles gives `io_ready` at cycle 2+n+1.
- Timeout: `io_ready` at cycle 3+TIMEOUT.
- A miss gives `io_ready` at cycle 1.
- Back-to-back transactions: the next strobe is accepted in the IDLE cycle after DONE.

## Configuration
- `MCS_BRG_WAIT_EN` defined: ack/WAIT/timeout behaviour as above. The timeout flag is live.
- Undefined:
  - `fp_ack` is ignored and treated as always 1, so REQ always goes to DONE (fixed latency 2).
  - The WAIT state and the counter are not synthesised.
  - `err_flags[1]` is tied to 0.

## Structure
- Package `mcs_brg_pkg` holds:
  - the `brg_state_t` enum (IDLE/REQ/WAIT/DONE),
  - the `brg_op_t` enum (RD/WR),
  - the error-flag bit index constants,
  - a `MISS_DATA` constant of 32'h0.
- Sub-module `brg_addr_decode` (combinational): computes hit and slot index from the parameters. Both the bridge and the bench reuse it.

## Test plan
- Write `32'h1234_5678` to `BRG_BASE + 4`, slot 0, with zero-wait ack: `fp_addr=1`, `fp_cs=2'b01`, `fp_wr` pulse in cycle 1, `io_ready` in cycle 2.
- Read slot 1 (`BRG_BASE + (1<<23)`, N_SLOT=2, ADDR_W=21) with ack after 3 WAIT cycles and data `32'hCAFE_0001`: `io_ready` at cycle 6, `io_read_data=32'hCAFE_0001`.
- Read with `fp_ack` stuck low, TIMEOUT=4, macro on: `io_ready` at cycle 7, data 0, `err_flags=3'b010`. Then pulse `err_clr`: flags return to 0.
- Read of address `32'h8000_0000`: `io_ready` at cycle 1, data 0, `err_flags[0]=1`, `fp_cs` stays 0.
- Strobe issued during WAIT: ignored, `err_flags[2]=1`, and the original transaction completes normally.
- Drop `reset_n` during WAIT: `fp_cs`=0 immediately, no `io_ready`. After release, a new read completes at cycle 2.

Source files
------------

// File: rtl/mcs_brg_pkg.sv
// Shared types and constants for the N-slot MCS I/O-bus bridge.
// Optional ack/wait/timeout support is enabled with MCS_BRG_WAIT_EN.
package mcs_brg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } brg_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } brg_op_t;

    localparam int ERR_MISS = 0;
    localparam int ERR_TMO  = 1;
    localparam int ERR_OVR  = 2;

    localparam logic [31:0] MISS_DATA = 32'h0;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brg_addr_decode.sv
// Combinational window decoder: base-tag compare plus slot index.
// Shared by the bridge and its testbench.
module brg_addr_decode
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_SLOT   = 2,
    parameter int          ADDR_W   = 21,
    localparam int         SEL_W    = sel_w(N_SLOT)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] slot
);

    localparam int LSB = ADDR_W + 2 + SEL_W;

    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W+1:0];

    // Tag above the slot field must match the base; slot must exist.
    always_comb begin
        slot = addr[ADDR_W+2 +: SEL_W];
        hit  = ((addr >> LSB) == (BRG_BASE >> LSB))
            && ({1'b0, slot} < (SEL_W+1)'(N_SLOT));
    end

endmodule

// File: rtl/mcs_bus_bridge_nslot.sv
// MCS I/O bus to N_SLOT FPro windows, registered, one transaction at a time.
// Define MCS_BRG_WAIT_EN for per-slot ack, WAIT state and timeout.
module mcs_bus_bridge_nslot
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_SLOT   = 2,
    parameter int          ADDR_W   = 21,
    parameter int          TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_addr_strobe,
    input  logic                io_read_strobe,
    input  logic                io_write_strobe,
    input  logic [3:0]          io_byte_enable,
    input  logic [31:0]         io_address,
    input  logic [31:0]         io_write_data,
    output logic [31:0]         io_read_data,
    output logic                io_ready,
    output logic [N_SLOT-1:0]   fp_cs,
    output logic                fp_wr,
    output logic                fp_rd,
    output logic [ADDR_W-1:0]   fp_addr,
    output logic [3:0]          fp_be,
    output logic [31:0]         fp_wr_data,
    input  logic [32*N_SLOT-1:0] fp_rd_data,
    input  logic [N_SLOT-1:0]   fp_ack,
    input  logic                err_clr,
    output logic [2:0]          err_flags
);

    localparam int SEL_W = sel_w(N_SLOT);

    brg_state_t       state;
    brg_state_t       state_nx;
    brg_op_t          op;
    logic [SEL_W-1:0] slot;
    logic [SEL_W-1:0] dec_slot;
    logic             dec_hit;
    logic             start;
    logic             active;
    logic             ack;
    logic             capture;
    logic             miss_ev;
    logic             tmo_ev;
    logic             ovr_ev;
    logic [31:0]      rd_sel;
    logic [31:0]      rdata_q;
    logic [2:0]       err_q;

    brg_addr_decode #(
        .BRG_BASE (BRG_BASE),
        .N_SLOT   (N_SLOT),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .addr (io_address),
        .hit  (dec_hit),
        .slot (dec_slot)
    );

    assign start  = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign active = (state == REQ) || (state == WAIT);
    assign ovr_ev = start && (state != IDLE);
    assign rd_sel = fp_rd_data[32*slot +: 32];

`ifdef MCS_BRG_WAIT_EN
    logic [15:0] cnt;
    logic        tmo;

    assign ack = fp_ack[slot];
    assign tmo = (cnt == 16'(TIMEOUT));

    // Wait-cycle counter, live only while parked in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == WAIT && state_nx == WAIT) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_cfg;

    assign ack        = 1'b1;
    assign unused_cfg = ^{fp_ack, 16'(TIMEOUT)};
`endif

    // Next-state decode and single-cycle event strobes.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        miss_ev  = 1'b0;
        tmo_ev   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dec_hit) begin
                        state_nx = REQ;
                    end else begin
                        state_nx = DONE;
                        miss_ev  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ack) begin
                    state_nx = DONE;
                    capture  = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
`ifdef MCS_BRG_WAIT_EN
            WAIT: begin
                if (ack) begin
                    state_nx = DONE;
                    capture  = 1'b1;
                end else if (tmo) begin
                    state_nx = DONE;
                    tmo_ev   = 1'b1;
                end
            end
`else
            WAIT: state_nx = IDLE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One-hot chip select for the latched slot while the access is open.
    always_comb begin
        fp_cs = '0;
        for (int k = 0; k < N_SLOT; k++) begin
            fp_cs[k] = active && (slot == SEL_W'(k));
        end
    end

    assign fp_wr        = (state == REQ) && (op == WR);
    assign fp_rd        = (state == REQ) && (op == RD);
    assign io_ready     = (state == DONE);
    assign io_read_data = rdata_q;
    assign err_flags    = err_q;

    // State, request latch, returned data and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= RD;
            slot       <= '0;
            fp_addr    <= '0;
            fp_be      <= '0;
            fp_wr_data <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op         <= io_write_strobe ? WR : RD;
                slot       <= dec_slot;
                fp_addr    <= io_address[ADDR_W+1:2];
                fp_be      <= io_byte_enable;
                fp_wr_data <= io_write_data;
            end
            if (capture && op == RD) begin
                rdata_q <= rd_sel;
            end
            if (miss_ev || (tmo_ev && op == RD)) begin
                rdata_q <= MISS_DATA;
            end
            err_q <= (err_q & ~{3{err_clr}})
                   | {ovr_ev, tmo_ev, miss_ev};
        end
    end

endmodule

// File: tb/tb_mcs_bus_bridge_nslot.sv
// Self-checking bench for mcs_bus_bridge_nslot (N_SLOT=2, TIMEOUT=4).
// Follows MCS_BRG_WAIT_EN the same way the RTL does.
module tb_mcs_bus_bridge_nslot;
    import mcs_brg_pkg::*;

    localparam logic [31:0] BASE = 32'hc000_0000;
    localparam int TMO = 4;
`ifdef MCS_BRG_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic        io_ready;
    logic [1:0]  fp_cs;
    logic        fp_wr, fp_rd;
    logic [20:0] fp_addr;
    logic [3:0]  fp_be;
    logic [31:0] fp_wr_data;
    logic [63:0] fp_rd_data;
    logic [1:0]  fp_ack;
    logic        err_clr;
    logic [2:0]  err_flags;
    logic [31:0] rdv [2];

    always #5 clk = ~clk;
    assign fp_rd_data = {rdv[1], rdv[0]};

    mcs_bus_bridge_nslot #(
        .BRG_BASE (BASE),
        .N_SLOT   (2),
        .ADDR_W   (21),
        .TIMEOUT  (TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_be           (fp_be),
        .fp_wr_data      (fp_wr_data),
        .fp_rd_data      (fp_rd_data),
        .fp_ack          (fp_ack),
        .err_clr         (err_clr),
        .err_flags       (err_flags)
    );

    logic [31:0] dec_addr;
    logic        dec_hit;
    logic [1:0]  dec_slot;

    brg_addr_decode #(
        .BRG_BASE (BASE),
        .N_SLOT   (3),
        .ADDR_W   (21)
    ) u_dec3 (
        .addr (dec_addr),
        .hit  (dec_hit),
        .slot (dec_slot)
    );

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [1:0]  slot;
    } dec_vec_t;

    dec_vec_t    tbl [8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_rdata;
    logic [2:0]  m_flags;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // One transaction; entered and left just after a rising edge.
    task automatic xact(input logic [31:0] addr, input bit wr,
                        input int nwait, input logic [31:0] wd,
                        input logic [3:0] be, input int inj,
                        input bit clr, input bit both);
        bit hit;
        int slot;
        int lat;
        int ack_cyc;
        bit seen;
        hit  = (addr[31:24] == BASE[31:24]);
        slot = int'(addr[23]);
        if (!hit) lat = 1;
        else if (!WAIT_EN || nwait == 0) lat = 2;
        else if (nwait < 0) lat = 3 + TMO;
        else lat = 3 + nwait;
        ack_cyc = (nwait == 0) ? 1 : ((nwait > 0) ? 2 + nwait : -1);
        rdv[0] = $urandom;
        rdv[1] = $urandom;
        if (clr) m_flags = 3'b000;
        if (!hit) begin
            m_flags[0] = 1'b1;
            m_rdata    = 32'h0;
        end else if (WAIT_EN && nwait < 0) begin
            m_flags[1] = 1'b1;
            if (!wr) m_rdata = 32'h0;
        end else if (!wr) begin
            m_rdata = rdv[slot];
        end
        if (inj > 0) m_flags[2] = 1'b1;
        io_address      = addr;
        io_write_data   = wd;
        io_byte_enable  = be;
        io_addr_strobe  = 1'b1;
        io_write_strobe = wr;
        io_read_strobe  = !wr || both;
        err_clr         = clr;
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_read_strobe  = 1'b0;
        err_clr         = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= lat + 2 && !seen; c++) begin
            fp_ack = 2'b00;
            if (hit && c == ack_cyc) fp_ack[slot] = 1'b1;
            io_addr_strobe = (c == inj);
            io_read_strobe = (c == inj);
            @(negedge clk);
            chk("fp_cs", {30'b0, fp_cs},
                (hit && c < lat) ? (32'd1 << slot) : 32'd0);
            chk("fp_wr", {31'b0, fp_wr}, {31'b0, hit && wr && c == 1});
            chk("fp_rd", {31'b0, fp_rd}, {31'b0, hit && !wr && c == 1});
            if (hit && c == 1) begin
                chk("fp_addr", {11'b0, fp_addr}, {11'b0, addr[22:2]});
                chk("fp_be", {28'b0, fp_be}, {28'b0, be});
                if (wr) chk("fp_wr_data", fp_wr_data, wd);
            end
            chk("io_ready", {31'b0, io_ready}, {31'b0, c == lat});
            if (io_ready) begin
                seen = 1'b1;
                chk("io_read_data", io_read_data, m_rdata);
                chk("err_flags", {29'b0, err_flags}, {29'b0, m_flags});
            end
            @(posedge clk);
            #1;
        end
        fp_ack         = 2'b00;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_never actual=0 required=1 t=%0t", $time);
        end
    endtask

    task automatic clear_flags;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_flags = 3'b000;
        @(negedge clk);
        chk("err_clr", {29'b0, err_flags}, {29'b0, m_flags});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          nw;
        int          kind;

        tbl[0] = '{32'hc000_0000, 1'b1, 2'd0};
        tbl[1] = '{32'hc080_0000, 1'b1, 2'd1};
        tbl[2] = '{32'hc100_0000, 1'b1, 2'd2};
        tbl[3] = '{32'hc180_0000, 1'b0, 2'd3};
        tbl[4] = '{32'hc200_0000, 1'b0, 2'd0};
        tbl[5] = '{32'h8000_0000, 1'b0, 2'd0};
        tbl[6] = '{32'hc07f_fffc, 1'b1, 2'd0};
        tbl[7] = '{32'hc1ff_fffc, 1'b0, 2'd3};

        reset_n = 1'b0;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable = 4'h0;
        io_address = 32'h0;
        io_write_data = 32'h0;
        fp_ack = 2'b00;
        err_clr = 1'b0;
        rdv[0] = 32'h0;
        rdv[1] = 32'h0;
        dec_addr = 32'h0;
        m_rdata = 32'h0;
        m_flags = 3'b000;

        #1;
        chk("rst_ready", {31'b0, io_ready}, 32'd0);
        chk("rst_cs", {30'b0, fp_cs}, 32'd0);
        chk("rst_rdata", io_read_data, 32'd0);
        chk("rst_flags", {29'b0, err_flags}, 32'd0);
        chk("rst_addr", {11'b0, fp_addr}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            dec_addr = tbl[i].addr;
            #1;
            chk("dec_hit", {31'b0, dec_hit}, {31'b0, tbl[i].hit});
            chk("dec_slot", {30'b0, dec_slot}, {30'b0, tbl[i].slot});
        end

        @(posedge clk);
        #1;
        xact(BASE + 32'd4, 1'b1, 0, 32'h1234_5678, 4'hf, 0, 1'b0, 1'b0);
        xact(BASE + (32'd1 << 23), 1'b0, 3, 32'h0, 4'hf, 0, 1'b0, 1'b0);
        rdv[1] = 32'hCAFE_0001;
        xact(BASE + (32'd1 << 23) + 32'h10, 1'b0, 0, 32'h0, 4'h3,
             0, 1'b0, 1'b0);
        xact(BASE + 32'h20, 1'b0, -1, 32'h0, 4'hf, 0, 1'b0, 1'b0);
        clear_flags();
        xact(32'h8000_0000, 1'b0, 0, 32'h0, 4'hf, 0, 1'b0, 1'b0);
        xact(BASE + (32'd1 << 23) + 32'h40, 1'b0, 2, 32'h0, 4'hf,
             WAIT_EN ? 3 : 1, 1'b0, 1'b0);
        xact(32'h8000_0010, 1'b0, 0, 32'h0, 4'hf, 0, 1'b1, 1'b0);
        xact(BASE + (32'd1 << 23) + 32'h8, 1'b1, 0, 32'h5a5a_a5a5,
             4'h1, 0, 1'b0, 1'b1);
        clear_flags();

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0) begin
                a = {8'h40 + 8'($urandom_range(0, 63)), 24'($urandom)};
            end else begin
                a = BASE | (32'($urandom_range(0, 1)) << 23)
                  | {9'b0, 21'($urandom), 2'b00};
            end
            if ($urandom_range(0, 5) == 0) nw = -1;
            else nw = int'($urandom_range(0, TMO - 1));
            xact(a, 1'($urandom), nw, $urandom, 4'($urandom),
                 0, 1'b0, 1'b0);
        end

        io_address = BASE;
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        fp_ack = 2'b00;
        @(posedge clk);
        #1;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        if (WAIT_EN) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_cs", {30'b0, fp_cs}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        m_flags = 3'b000;
        m_rdata = 32'h0;
        chk("rst_mid_cs", {30'b0, fp_cs}, 32'd0);
        chk("rst_mid_ready", {31'b0, io_ready}, 32'd0);
        chk("rst_mid_flags", {29'b0, err_flags}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_ready", {31'b0, io_ready}, 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        xact(BASE + (32'd1 << 23) + 32'h4, 1'b0, 0, 32'h0, 4'hf,
             0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
